// File: rtl/fetch_pc_unit.sv
// Fetch-side PC unit for the 5-stage MIPS pipeline: owns the fetch PC and the
// IF/ID register, and resolves the decode-stage redirect (branch, jr, j/jal).
// Branches are delayed, so the instruction after a redirect is never flushed.
module fetch_pc_unit #(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        pc_control,
    input  logic [31:0]       rs_data_d,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       instr_d,
    output logic [ADDR_W-1:0] pc_d,
    output logic [ADDR_W-1:0] pc8_d,
    output logic              valid_d,
    output logic              pc_align_err
);

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JR     = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] pc4_d;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] btarget;
    logic [ADDR_W-1:0] jtarget;
    logic [ADDR_W-1:0] rtarget;
    logic [ADDR_W-1:0] npc;
    pc_sel_e           sel;
    logic              jr_misaligned;

    assign sel   = pc_sel_e'(pc_control);

    // All address arithmetic wraps silently modulo 2^ADDR_W.
    assign seq   = pc_f + ADDR_W'(4);
    assign pc4_d = pc_d + ADDR_W'(4);
    assign pc8_d = pc_d + ADDR_W'(8);

    // Word offset, sign-extended so backward branches subtract.
    assign br_off  = {{(ADDR_W-18){instr_d[15]}}, instr_d[15:0], 2'b00};
    assign btarget = pc4_d + br_off;

    // Region bits come from the delay-slot address, not from pc_d itself.
    assign jtarget = {pc4_d[ADDR_W-1:28], instr_d[25:0], 2'b00};

    // Low two bits are forced to zero; a misaligned rs is flagged separately.
    assign rtarget = ADDR_W'({rs_data_d[31:2], 2'b00});

    // A reset bubble in D must not redirect, whatever pc_control says.
    assign jr_misaligned = valid_d && (sel == PC_JR) && (rs_data_d[1:0] != 2'b00);

    assign imem_addr = pc_f;

    // Next-PC select from the decode-stage redirect code.
    always_comb begin
        // NOTE: npc gets a default before the case so no path leaves it unassigned, which would infer a latch.
        npc = seq;
        if (valid_d) begin
            unique case (sel)
                PC_SEQ:    npc = seq;
                PC_BRANCH: npc = btarget;
                PC_JR:     npc = rtarget;
                PC_JUMP:   npc = jtarget;
                default:   npc = seq;
            endcase
        end
    end

    // PC and IF/ID register: reset beats stall, stall freezes everything.
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every update in this block sees the pre-edge values of pc_f and friends.
        if (reset) begin
            pc_f         <= RESET_PC;
            instr_d      <= 32'h0;
            pc_d         <= RESET_PC;
            valid_d      <= 1'b0;
            pc_align_err <= 1'b0;
        end else if (!stall) begin
            pc_f         <= npc;
            instr_d      <= imem_rdata;
            pc_d         <= pc_f;
            valid_d      <= 1'b1;
            pc_align_err <= jr_misaligned;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: a table of per-cycle stimulus with
// hand-derived post-edge expectations, fed through a scoreboard queue.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_control;
    logic [31:0] rs_data_d;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        pc_align_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        rst;
        logic        stl;
        logic [1:0]  pcc;
        logic [31:0] rs;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        valid;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    fetch_pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_control   (pc_control),
        .rs_data_d    (rs_data_d),
        .imem_rdata   (imem_rdata),
        .imem_addr    (imem_addr),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc8_d        (pc8_d),
        .valid_d      (valid_d),
        .pc_align_err (pc_align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: two real instructions, a tagged filler elsewhere.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_3008: return 32'h1000_FFFE;   // beq, imm = -2
            32'h0000_3010: return 32'h0C00_0C10;   // jal, index 0x0000C10
            default:       return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    always_comb imem_rdata = imem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        reset      = v.rst;
        stall      = v.stl;
        pc_control = v.pcc;
        rs_data_d  = v.rs;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard[%0d]: queue empty, expected one entry", idx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("imem_addr[%0d]", idx), imem_addr, e.addr);
            check($sformatf("instr_d[%0d]", idx), instr_d, e.instr);
            check($sformatf("pc_d[%0d]", idx), pc_d, e.pcd);
            check($sformatf("pc8_d[%0d]", idx), pc8_d, e.pcd + 32'd8);
            check($sformatf("valid_d[%0d]", idx), {31'b0, valid_d}, {31'b0, e.valid});
            check($sformatf("pc_align_err[%0d]", idx), {31'b0, pc_align_err}, {31'b0, e.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        pc_control = 2'd0;
        rs_data_d  = 32'h0;

        //                  rst   stl   pcc   rs            addr          instr         pc_d          v     err
        // Reset and sequential fetch.
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'd0, 32'h0,        32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_3004, 32'hA5A5_3000, 32'h0000_3000, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_3008, 32'hA5A5_3004, 32'h0000_3004, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_300C, 32'h1000_FFFE, 32'h0000_3008, 1'b1, 1'b0});
        // Backward beq at 3008 -> 3004; delay slot 300C still reaches D.
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd1, 32'h0,        32'h0000_3004, 32'hA5A5_300C, 32'h0000_300C, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_3008, 32'hA5A5_3004, 32'h0000_3004, 1'b1, 1'b0});
        // Not-taken beq, then walk to the jal at 3010.
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_300C, 32'h1000_FFFE, 32'h0000_3008, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_3010, 32'hA5A5_300C, 32'h0000_300C, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_3014, 32'h0C00_0C10, 32'h0000_3010, 1'b1, 1'b0});
        // jal index 0xC10 -> 0x3040.
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd3, 32'h0,        32'h0000_3040, 32'hA5A5_3014, 32'h0000_3014, 1'b1, 1'b0});
        // Misaligned jr: target 3020, error for one cycle.
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd2, 32'h0000_3021, 32'h0000_3020, 32'hA5A5_3040, 32'h0000_3040, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_3024, 32'hA5A5_3020, 32'h0000_3020, 1'b1, 1'b0});
        // Branch held under a 3-cycle stall; imm 0x3020 -> 3024 + 0xC080 = F0A4.
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd1, 32'h0,        32'h0000_3024, 32'hA5A5_3020, 32'h0000_3020, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd1, 32'h0,        32'h0000_3024, 32'hA5A5_3020, 32'h0000_3020, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd1, 32'h0,        32'h0000_3024, 32'hA5A5_3020, 32'h0000_3020, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd1, 32'h0,        32'h0000_F0A4, 32'hA5A5_3024, 32'h0000_3024, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_F0A8, 32'hA5A5_F0A4, 32'h0000_F0A4, 1'b1, 1'b0});
        // Error set, then held through a stall, then reset during stall.
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd2, 32'h0000_1003, 32'h0000_1000, 32'hA5A5_F0A8, 32'h0000_F0A8, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'd0, 32'h0,        32'h0000_1000, 32'hA5A5_F0A8, 32'h0000_F0A8, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 2'd0, 32'h0,        32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b0});
        // Bubble in D ignores pc_control.
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd1, 32'h0,        32'h0000_3004, 32'hA5A5_3000, 32'h0000_3000, 1'b1, 1'b0});
        // Aligned jr to the top of memory, sequential wrap, backward branch across 0.
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hA5A5_3004, 32'h0000_3004, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'hFFFF_FFFC, 32'hA5A5_FFF8, 32'hFFFF_FFF8, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_0000, 32'hA5A5_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'd1, 32'h0,        32'hFFFF_FFF0, 32'hA5A5_0000, 32'h0000_0000, 1'b1, 1'b0});

        foreach (vecs[i]) apply(vecs[i], i);

        // Hand-written: a misaligned jr seen only while stalled must not raise
        // the flag; taken unstalled it does; an aligned jr then clears it.
        apply(vec_t'{1'b0, 1'b1, 2'd2, 32'h0000_0003, 32'hFFFF_FFF0, 32'hA5A5_0000, 32'h0000_0000, 1'b1, 1'b0}, 100);
        apply(vec_t'{1'b0, 1'b0, 2'd2, 32'h0000_0102, 32'h0000_0100, 32'hA5A5_FFF0, 32'hFFFF_FFF0, 1'b1, 1'b1}, 101);
        apply(vec_t'{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0000_0200, 32'hA5A5_0100, 32'h0000_0100, 1'b1, 1'b0}, 102);

        // Hand-written: two-cycle reset with stall low, then first fetch.
        apply(vec_t'{1'b1, 1'b0, 2'd3, 32'h0,        32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b0}, 103);
        apply(vec_t'{1'b1, 1'b0, 2'd0, 32'h0,        32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b0}, 104);
        apply(vec_t'{1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_3004, 32'hA5A5_3000, 32'h0000_3000, 1'b1, 1'b0}, 105);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch end of the D-stage control interface. Owns the PC register and the IF/ID pipeline register.
- Consumes the 2-bit PC-select code and the jump-register operand produced during decode, and drives the next instruction address.
- Sits between the instruction memory and the decode stage of the 5-stage MIPS pipeline.
- Uses delayed branches: the instruction after a branch or jump always executes and is never flushed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC and address width; all arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard hold; freezes PC and IF/ID register.
- pc_control  in  2  D-stage select: 0 = sequential, 1 = taken branch, 2 = jump register, 3 = jump immediate.
- rs_data_d  in  32  forwarded rs value for jump-register.
- imem_rdata  in  32  instruction word at imem_addr; combinational, same cycle.
- imem_addr  out  ADDR_W  current fetch PC (pc_f).
- instr_d  out  32  IF/ID instruction register.
- pc_d  out  ADDR_W  PC of instr_d.
- pc8_d  out  ADDR_W  pc_d+8, the link address for jal/jalr.
- valid_d  out  1  instr_d holds a fetched instruction (not a reset bubble).
- pc_align_err  out  1  registered flag: a jump-register target with rs_data_d[1:0] != 0 was taken.

Behaviour:
- Reset (synchronous, takes priority over stall):
  - pc_f = RESET_PC
  - instr_d = 32'h0 (nop)
  - pc_d = RESET_PC
  - valid_d = 0
  - pc_align_err = 0
- Reset asserted mid-operation discards all in-flight state on that edge. The first fetch after reset is RESET_PC, and it appears on instr_d one cycle after reset deasserts.
- Derived values:
  - seq = pc_f+4
  - imm16 = instr_d[15:0]
  - btarget = pc_d+4 + (sign_extend(imm16)<<2)
  - jtarget = {pc_d[31:28]+4-carry-adjusted, i.e. (pc_d+4)[31:28], instr_d[25:0], 2'b00}
  - rtarget = {rs_data_d[31:2], 2'b00}
- Next PC: if valid_d=0, npc = seq. Otherwise select by pc_control: 0 → seq, 1 → btarget, 2 → rtarget, 3 → jtarget.
- Each cycle with stall=0:
  - pc_f <= npc
  - instr_d <= imem_rdata
  - pc_d <= pc_f
  - valid_d <= 1
- With stall=1, pc_f, instr_d, pc_d and valid_d hold. A redirect requested during stall is not lost: pc_control is re-evaluated from the held instr_d and takes effect on the first unstalled edge.
- Latency:
  - redirect decided in D at cycle t → pc_f = target at t+1
  - delay-slot instruction (fetched at t) enters D at t+1
  - target instruction enters D at t+2
- pc_align_err is set on the unstalled edge that takes pc_control=2 with rs_data_d[1:0]!=0. It clears on the next unstalled edge that does not meet that condition; it holds during stall.
- Wrap-around: seq and btarget wrap modulo 2^ADDR_W with no error. Backward branches use two's-complement offsets.
- pc8_d is combinational: pc_d+8.
- Simultaneous stall and reset: reset wins.

Test Plan:
- Reset, then run 4 unstalled cycles with pc_control=0 → imem_addr = 3000, 3004, 3008, 300C. instr_d follows imem_rdata one cycle later. valid_d = 0 on the first post-reset cycle, then 1.
- instr_d = beq with imm = 0xFFFE, pc_d = 3008, pc_control=1 → next imem_addr = 3004. The delay slot at 300C still reaches instr_d.
- instr_d = jal with index 0x0000C10, pc_d = 3010, pc_control=3 → imem_addr = 0x00003040, pc8_d = 3018.
- pc_control=2, rs_data_d = 0x00003021 → imem_addr = 3020 and pc_align_err = 1 for one cycle. A following sequential cycle clears it.
- Hold stall=1 for 3 cycles while pc_control=1 → imem_addr, instr_d and pc_d are unchanged. On stall release the branch target is loaded exactly once.
- Assert reset for one cycle mid-stream with stall=1 → imem_addr = 3000, instr_d = 0, valid_d = 0 on the next cycle.
